// File: rtl/int_branch_resolver.sv
// rtl/int_branch_resolver.sv - integer write-back stage with oldest-mispredict recovery request
module int_branch_resolver #(
    parameter int ISSUE_WIDTH = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int PREG_W      = 7,
    parameter int AL_PTR_W    = 6,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          clear,
    input  logic [ISSUE_WIDTH-1:0]        in_valid,
    input  logic [ISSUE_WIDTH*DATA_W-1:0] in_data,
    input  logic [ISSUE_WIDTH-1:0]        in_data_valid,
    input  logic [ISSUE_WIDTH-1:0]        in_wr_reg,
    input  logic [ISSUE_WIDTH*PREG_W-1:0] in_dst_preg,
    input  logic [ISSUE_WIDTH*AL_PTR_W-1:0] in_al_ptr,
    input  logic [ISSUE_WIDTH-1:0]        in_br_valid,
    input  logic [ISSUE_WIDTH-1:0]        in_mispred,
    input  logic [ISSUE_WIDTH*ADDR_W-1:0] in_next_addr,
    input  logic [AL_PTR_W-1:0]           al_head_ptr,
    input  logic                          rec_ack,
    input  logic                          rec_done,
    output logic [ISSUE_WIDTH-1:0]        rf_we,
    output logic [ISSUE_WIDTH*PREG_W-1:0] rf_waddr,
    output logic [ISSUE_WIDTH*DATA_W-1:0] rf_wdata,
    output logic [ISSUE_WIDTH-1:0]        replay,
    output logic                          rec_req,
    output logic [AL_PTR_W-1:0]           rec_al_ptr,
    output logic [ADDR_W-1:0]             rec_addr,
    output logic [CNT_W-1:0]              br_count,
    output logic [CNT_W-1:0]              mispred_count
);
    localparam int INC_W = $clog2(ISSUE_WIDTH + 1);
    localparam int SUM_W = CNT_W + INC_W;

    typedef enum logic [1:0] {IDLE, REQ, RECOVER} state_t;

    state_t state, stateNext;
    logic [ISSUE_WIDTH-1:0]          vReg, dataValidReg, wrRegReg, brValidReg, mispredReg;
    logic [ISSUE_WIDTH*DATA_W-1:0]   dataReg;
    logic [ISSUE_WIDTH*PREG_W-1:0]   pregReg;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0] ptrReg;
    logic [ISSUE_WIDTH*ADDR_W-1:0]   nextAddrReg;
    logic [AL_PTR_W-1:0]             recPtrReg, recPtrNext, oldPtr;
    logic [ADDR_W-1:0]               recAddrReg, recAddrNext, oldAddr;
    logic [CNT_W-1:0]                brCnt, mpCnt;
    logic [ISSUE_WIDTH-1:0]          mp, brHit;
    logic                            anyMp;

    function automatic logic [AL_PTR_W-1:0] ageOf(input logic [AL_PTR_W-1:0] ptr,
                                                  input logic [AL_PTR_W-1:0] head);
        return ptr - head;
    endfunction

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt,
                                                input logic [ISSUE_WIDTH-1:0] hits);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt);
        for (int i = 0; i < ISSUE_WIDTH; i++) sum = sum + SUM_W'(hits[i]);
        if (sum > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vReg         <= '0;
            dataValidReg <= '0;
            wrRegReg     <= '0;
            brValidReg   <= '0;
            mispredReg   <= '0;
            dataReg      <= '0;
            pregReg      <= '0;
            ptrReg       <= '0;
            nextAddrReg  <= '0;
        end else if (!stall) begin
            vReg         <= in_valid & {ISSUE_WIDTH{~clear}};
            dataValidReg <= in_data_valid;
            wrRegReg     <= in_wr_reg;
            brValidReg   <= in_br_valid;
            mispredReg   <= in_mispred;
            dataReg      <= in_data;
            pregReg      <= in_dst_preg;
            ptrReg       <= in_al_ptr;
            nextAddrReg  <= in_next_addr;
        end
    end

    // Stall masks every lane-level effect so a held op is seen exactly once.
    assign rf_we    = vReg & wrRegReg & dataValidReg & {ISSUE_WIDTH{~stall}};
    assign replay   = vReg & ~dataValidReg & {ISSUE_WIDTH{~stall}};
    assign rf_waddr = pregReg;
    assign rf_wdata = dataReg;
    assign mp       = vReg & brValidReg & mispredReg & {ISSUE_WIDTH{~stall}};
    assign brHit    = vReg & brValidReg & dataValidReg & {ISSUE_WIDTH{~stall}};

    // Strict compare keeps the lower lane on equal ages.
    always_comb begin
        anyMp   = 1'b0;
        oldPtr  = '0;
        oldAddr = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (mp[i] && (!anyMp || ageOf(ptrReg[i*AL_PTR_W +: AL_PTR_W], al_head_ptr)
                                    < ageOf(oldPtr, al_head_ptr))) begin
                anyMp   = 1'b1;
                oldPtr  = ptrReg[i*AL_PTR_W +: AL_PTR_W];
                oldAddr = nextAddrReg[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        stateNext   = state;
        recPtrNext  = recPtrReg;
        recAddrNext = recAddrReg;
        case (state)
            IDLE: begin
                if (anyMp) begin
                    recPtrNext  = oldPtr;
                    recAddrNext = oldAddr;
                    stateNext   = REQ;
                end
            end
            REQ: begin
                if (rec_ack) begin
                    stateNext = RECOVER;
                end else if (anyMp && ageOf(oldPtr, al_head_ptr) < ageOf(recPtrReg, al_head_ptr)) begin
                    recPtrNext  = oldPtr;
                    recAddrNext = oldAddr;
                end
            end
            RECOVER: begin
                if (rec_done) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            recPtrReg  <= '0;
            recAddrReg <= '0;
            brCnt      <= '0;
            mpCnt      <= '0;
        end else begin
            state      <= stateNext;
            recPtrReg  <= recPtrNext;
            recAddrReg <= recAddrNext;
            brCnt      <= satAdd(brCnt, brHit);
            mpCnt      <= satAdd(mpCnt, mp);
        end
    end

    assign rec_req       = (state == REQ);
    assign rec_al_ptr    = recPtrReg;
    assign rec_addr      = recAddrReg;
    assign br_count      = brCnt;
    assign mispred_count = mpCnt;
endmodule

// File: tb/tb_int_branch_resolver.sv
// tb/tb_int_branch_resolver.sv - randomized and directed bench for int_branch_resolver
module tb_int_branch_resolver;
    localparam int IW = 2, DW = 32, AW = 32, PW = 7, APW = 6, CW = 16;

    logic clk = 1'b0, rst = 1'b0, stall, clear, rec_ack, rec_done;
    logic [IW-1:0] in_valid, in_data_valid, in_wr_reg, in_br_valid, in_mispred;
    logic [IW*DW-1:0] in_data;
    logic [IW*PW-1:0] in_dst_preg;
    logic [IW*APW-1:0] in_al_ptr;
    logic [IW*AW-1:0] in_next_addr;
    logic [APW-1:0] al_head_ptr;
    logic [IW-1:0] rf_we, replay, rf_we2, replay2;
    logic [IW*PW-1:0] rf_waddr, rf_waddr2;
    logic [IW*DW-1:0] rf_wdata, rf_wdata2;
    logic rec_req, rec_req2;
    logic [APW-1:0] rec_al_ptr, rec_al_ptr2;
    logic [AW-1:0] rec_addr, rec_addr2;
    logic [CW-1:0] br_count, mispred_count;
    logic [1:0] br_count2, mispred_count2;

    int nChecks = 0, nErrors = 0;

    typedef struct {
        bit v, dv, wr, br, mis;
        bit [DW-1:0] data;
        bit [AW-1:0] next;
        bit [PW-1:0] preg;
        bit [APW-1:0] ptr;
    } lane_t;
    lane_t pipe[IW];
    int mState;
    int mRecPtr, mBr, mMp, mBr2, mMp2;
    bit [AW-1:0] mRecAddr;
    localparam int ST_IDLE = 0, ST_REQ = 1, ST_REC = 2;

    int_branch_resolver dut (
        .clk(clk), .rst(rst), .stall(stall), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_data_valid(in_data_valid), .in_wr_reg(in_wr_reg), .in_dst_preg(in_dst_preg),
        .in_al_ptr(in_al_ptr), .in_br_valid(in_br_valid), .in_mispred(in_mispred),
        .in_next_addr(in_next_addr), .al_head_ptr(al_head_ptr), .rec_ack(rec_ack), .rec_done(rec_done),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .replay(replay), .rec_req(rec_req),
        .rec_al_ptr(rec_al_ptr), .rec_addr(rec_addr), .br_count(br_count), .mispred_count(mispred_count)
    );

    int_branch_resolver #(.CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst), .stall(stall), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_data_valid(in_data_valid), .in_wr_reg(in_wr_reg), .in_dst_preg(in_dst_preg),
        .in_al_ptr(in_al_ptr), .in_br_valid(in_br_valid), .in_mispred(in_mispred),
        .in_next_addr(in_next_addr), .al_head_ptr(al_head_ptr), .rec_ack(rec_ack), .rec_done(rec_done),
        .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2), .replay(replay2), .rec_req(rec_req2),
        .rec_al_ptr(rec_al_ptr2), .rec_addr(rec_addr2), .br_count(br_count2), .mispred_count(mispred_count2)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ageOf(int p, int head);
        return (p - head + 64) % 64;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < IW; i++) pipe[i] = '{default: 0};
        mState = ST_IDLE; mRecPtr = 0; mRecAddr = '0;
        mBr = 0; mMp = 0; mBr2 = 0; mMp2 = 0;
    endtask

    task automatic idleInputs();
        stall = 0; clear = 0; rec_ack = 0; rec_done = 0;
        in_valid = '0; in_data_valid = '0; in_wr_reg = '0; in_br_valid = '0; in_mispred = '0;
        in_data = '0; in_dst_preg = '0; in_al_ptr = '0; in_next_addr = '0;
    endtask

    task automatic setLane(input int i, input bit v, input logic [DW-1:0] d, input bit dv, input bit wr,
                           input logic [PW-1:0] preg, input logic [APW-1:0] ptr, input bit br,
                           input bit mis, input logic [AW-1:0] nxt);
        in_valid[i] = v; in_data[i*DW +: DW] = d; in_data_valid[i] = dv; in_wr_reg[i] = wr;
        in_dst_preg[i*PW +: PW] = preg; in_al_ptr[i*APW +: APW] = ptr; in_br_valid[i] = br;
        in_mispred[i] = mis; in_next_addr[i*AW +: AW] = nxt;
    endtask

    task automatic checkOutputs();
        logic [IW-1:0] eWe, eRep;
        logic [IW*PW-1:0] eAddr;
        logic [IW*DW-1:0] eData;
        for (int i = 0; i < IW; i++) begin
            eWe[i]  = pipe[i].v && pipe[i].wr && pipe[i].dv && !stall;
            eRep[i] = pipe[i].v && !pipe[i].dv && !stall;
            eAddr[i*PW +: PW] = pipe[i].preg;
            eData[i*DW +: DW] = pipe[i].data;
        end
        checkVal("rf_we", 64'(rf_we), 64'(eWe));
        checkVal("replay", 64'(replay), 64'(eRep));
        checkVal("rf_waddr", 64'(rf_waddr), 64'(eAddr));
        checkVal("rf_wdata", 64'(rf_wdata), 64'(eData));
        checkVal("rec_req", 64'(rec_req), 64'(mState == ST_REQ));
        checkVal("rec_al_ptr", 64'(rec_al_ptr), 64'(mRecPtr));
        checkVal("rec_addr", 64'(rec_addr), 64'(mRecAddr));
        checkVal("br_count", 64'(br_count), 64'(mBr));
        checkVal("mispred_count", 64'(mispred_count), 64'(mMp));
        checkVal("br_count_small", 64'(br_count2), 64'(mBr2));
        checkVal("mispred_count_small", 64'(mispred_count2), 64'(mMp2));
    endtask

    task automatic modelClock();
        int nBr = 0, nMp = 0, best = -1, bestAge = 1000, head;
        head = int'(al_head_ptr);
        if (!stall) begin
            for (int i = 0; i < IW; i++) begin
                if (pipe[i].v && pipe[i].br && pipe[i].dv) nBr++;
                if (pipe[i].v && pipe[i].br && pipe[i].mis) begin
                    nMp++;
                    if (ageOf(pipe[i].ptr, head) < bestAge) begin
                        bestAge = ageOf(pipe[i].ptr, head);
                        best = i;
                    end
                end
            end
        end
        mBr  = (mBr + nBr > 65535) ? 65535 : mBr + nBr;
        mMp  = (mMp + nMp > 65535) ? 65535 : mMp + nMp;
        mBr2 = (mBr2 + nBr > 3) ? 3 : mBr2 + nBr;
        mMp2 = (mMp2 + nMp > 3) ? 3 : mMp2 + nMp;
        if (mState == ST_IDLE) begin
            if (best >= 0) begin
                mRecPtr = pipe[best].ptr; mRecAddr = pipe[best].next; mState = ST_REQ;
            end
        end else if (mState == ST_REQ) begin
            if (rec_ack) mState = ST_REC;
            else if (best >= 0 && bestAge < ageOf(mRecPtr, head)) begin
                mRecPtr = pipe[best].ptr; mRecAddr = pipe[best].next;
            end
        end else if (rec_done) begin
            mState = ST_IDLE;
        end
        if (!stall) begin
            for (int i = 0; i < IW; i++) begin
                pipe[i].v = in_valid[i] && !clear;
                pipe[i].dv = in_data_valid[i]; pipe[i].wr = in_wr_reg[i];
                pipe[i].br = in_br_valid[i]; pipe[i].mis = in_mispred[i];
                pipe[i].data = in_data[i*DW +: DW]; pipe[i].preg = in_dst_preg[i*PW +: PW];
                pipe[i].ptr = in_al_ptr[i*APW +: APW]; pipe[i].next = in_next_addr[i*AW +: AW];
            end
        end
    endtask

    task automatic stepCycle();
        #1;
        checkOutputs();
        modelClock();
        @(negedge clk);
    endtask

    initial begin
        int mpBefore, brBefore;
        modelReset();
        idleInputs();
        al_head_ptr = '0;
        repeat (2) @(negedge clk);
        checkOutputs();
        checkVal("reset_rec_req", 64'(rec_req), 64'd0);
        rst = 1'b1;

        // two clean ALU writes
        setLane(0, 1, 32'h11, 1, 1, 7'd5, 6'd0, 0, 0, 32'h0);
        setLane(1, 1, 32'h22, 1, 1, 7'd6, 6'd1, 0, 0, 32'h0);
        stepCycle();
        idleInputs(); #1;
        checkVal("t1_we", 64'(rf_we), 64'h3);
        checkVal("t1_waddr", 64'(rf_waddr), 64'({7'd6, 7'd5}));
        checkVal("t1_wdata", 64'(rf_wdata), 64'({32'h22, 32'h11}));
        checkVal("t1_replay", 64'(replay), 64'h0);
        stepCycle();

        // lane1 operands invalid: replay, no write, not counted as resolved branch
        brBefore = mBr;
        setLane(0, 1, 32'h33, 1, 1, 7'd7, 6'd2, 1, 0, 32'h0);
        setLane(1, 1, 32'h44, 0, 1, 7'd8, 6'd3, 1, 0, 32'h0);
        stepCycle();
        idleInputs(); #1;
        checkVal("t2_we", 64'(rf_we), 64'h1);
        checkVal("t2_replay", 64'(replay), 64'h2);
        stepCycle();
        #1;
        checkVal("t2_replay_once", 64'(replay), 64'h0);
        checkVal("t2_br_count", 64'(br_count), 64'(brBefore + 1));
        stepCycle();

        // oldest-by-age selection across the wrap of the active list
        al_head_ptr = 6'd60;
        setLane(0, 1, 32'h0, 1, 0, 7'd0, 6'd2, 1, 1, 32'hA000);
        setLane(1, 1, 32'h0, 1, 0, 7'd0, 6'd62, 1, 1, 32'hB000);
        stepCycle();
        idleInputs(); stepCycle();
        #1;
        checkVal("t3_req", 64'(rec_req), 64'h1);
        checkVal("t3_ptr", 64'(rec_al_ptr), 64'd62);
        checkVal("t3_addr", 64'(rec_addr), 64'hB000);
        rec_ack = 1; stepCycle();
        idleInputs(); rec_done = 1; stepCycle();
        idleInputs();

        // latch replacement in REQ, ignore in RECOVER
        al_head_ptr = 6'd0;
        setLane(0, 1, 32'h0, 1, 0, 7'd0, 6'd10, 1, 1, 32'h100);
        stepCycle();
        idleInputs(); stepCycle();
        #1;
        checkVal("t4_req", 64'(rec_req), 64'h1);
        checkVal("t4_ptr10", 64'(rec_al_ptr), 64'd10);
        setLane(0, 1, 32'h0, 1, 0, 7'd0, 6'd4, 1, 1, 32'h40);
        stepCycle();
        idleInputs(); stepCycle();
        #1;
        checkVal("t4_ptr4", 64'(rec_al_ptr), 64'd4);
        checkVal("t4_addr4", 64'(rec_addr), 64'h40);
        setLane(1, 1, 32'h0, 1, 0, 7'd0, 6'd12, 1, 1, 32'h120);
        stepCycle();
        idleInputs(); stepCycle();
        #1;
        checkVal("t4_ptr_young", 64'(rec_al_ptr), 64'd4);
        rec_ack = 1; stepCycle();
        idleInputs(); #1;
        checkVal("t4_recover_req", 64'(rec_req), 64'h0);
        mpBefore = mMp;
        setLane(0, 1, 32'h0, 1, 0, 7'd0, 6'd1, 1, 1, 32'h10);
        stepCycle();
        idleInputs(); stepCycle();
        #1;
        checkVal("t4_rec_ptr_held", 64'(rec_al_ptr), 64'd4);
        checkVal("t4_rec_count", 64'(mispred_count), 64'(mpBefore + 1));
        rec_done = 1; stepCycle();
        idleInputs(); #1;
        checkVal("t4_idle_req", 64'(rec_req), 64'h0);
        stepCycle();

        // stall holds a pending mispredict until released
        mpBefore = mMp;
        setLane(0, 1, 32'h55, 1, 1, 7'd9, 6'd7, 1, 1, 32'h70);
        stepCycle();
        idleInputs(); stall = 1; clear = 1; #1;
        checkVal("t5_we_stall", 64'(rf_we), 64'h0);
        checkVal("t5_req_stall", 64'(rec_req), 64'h0);
        stepCycle();
        stall = 1; in_valid = '1; stepCycle();
        idleInputs(); #1;
        checkVal("t5_we_release", 64'(rf_we), 64'h1);
        stepCycle();
        #1;
        checkVal("t5_req", 64'(rec_req), 64'h1);
        checkVal("t5_ptr", 64'(rec_al_ptr), 64'd7);
        checkVal("t5_count_once", 64'(mispred_count), 64'(mpBefore + 1));
        checkVal("t6_small_sat", 64'(mispred_count2), 64'd3);
        rec_ack = 1; stepCycle();
        idleInputs(); rec_done = 1; stepCycle();
        idleInputs();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            stall = ($urandom % 100) < 15;
            clear = ($urandom % 100) < 10;
            rec_ack = ($urandom % 100) < 30;
            rec_done = ($urandom % 100) < 30;
            al_head_ptr = APW'($urandom);
            for (int i = 0; i < IW; i++)
                setLane(i, ($urandom % 100) < 75, $urandom, ($urandom % 100) < 80, ($urandom % 100) < 70,
                        PW'($urandom), APW'($urandom), ($urandom % 100) < 50, ($urandom % 100) < 40,
                        $urandom);
            stepCycle();
        end

        // asynchronous reset while a request is outstanding
        idleInputs();
        al_head_ptr = 6'd0;
        repeat (3) begin rec_done = 1; stepCycle(); end
        idleInputs();
        setLane(0, 1, 32'h0, 1, 0, 7'd0, 6'd20, 1, 1, 32'h200);
        stepCycle();
        idleInputs(); stepCycle();
        #1;
        checkVal("t7_req_before", 64'(rec_req), 64'h1);
        rst = 1'b0; #1;
        checkVal("t7_req_async", 64'(rec_req), 64'h0);
        checkVal("t7_br_async", 64'(br_count), 64'h0);
        checkVal("t7_mp_async", 64'(mispred_count), 64'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
